// File: rtl/to_fp9_lanes.sv
// Converts packed FP4 / FP8 (E4M3, E5M2) / FP16 A and B operands into FP9 lanes,
// serialised LANES elements per beat, with per-beat and sticky exception status.
module to_fp9_lanes #(
   parameter int unsigned BUS_W     = 32,
   parameter int unsigned LANES     = 4,
   parameter logic [4:0]  FP4_CODE  = 5'd1,
   parameter logic [4:0]  FP8_CODE  = 5'd2,
   parameter logic [4:0]  FP16_CODE = 5'd3,
   parameter logic [2:0]  E4M3_CODE = 3'd0,
   parameter logic [2:0]  E5M2_CODE = 3'd1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           type_ab,
   input  logic [2:0]           type_ab_sub,
   input  logic [BUS_W-1:0]     a_i,
   input  logic [BUS_W-1:0]     b_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [9*LANES-1:0]   a_o,
   output logic [9*LANES-1:0]   b_o,
   output logic [LANES-1:0]     lane_mask_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [3:0]           flags_o,
   input  logic                 clr_status_i,
   output logic [3:0]           status_o
);

   localparam int unsigned N4    = BUS_W / 4;
   localparam int unsigned N8    = BUS_W / 8;
   localparam int unsigned N16   = BUS_W / 16;
   localparam int unsigned LAST4  = (N4 > LANES) ? N4 / LANES - 1 : 0;
   localparam int unsigned LAST8  = (N8 > LANES) ? N8 / LANES - 1 : 0;
   localparam int unsigned LAST16 = (N16 > LANES) ? N16 / LANES - 1 : 0;
   localparam int unsigned IDX_W  = (LAST4 > 0) ? $clog2(LAST4 + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [2:0] {F_FP4, F_E4M3, F_E5M2, F_FP16, F_BAD} fmt_t;

   state_t             state;
   fmt_t               fmt_q;
   fmt_t               fmt_in;
   logic [BUS_W-1:0]   a_q;
   logic [BUS_W-1:0]   b_q;
   logic [IDX_W-1:0]   beat_idx;
   logic [IDX_W-1:0]   last_idx;
   logic               last_beat;
   logic               accept;
   logic               beat_hs;

   // Result packing for all converters: {err, nan, uf, sat, fp9[8:0]}
   function automatic logic [12:0] cvt_fp4(input logic [3:0] x);
      logic [12:0] r;
      if (x[2:0] == 3'b000)
         r = {4'b0000, x[3], 8'h00};
      else if (x[2:0] == 3'b001)
         r = {4'b0000, x[3], 4'd6, 4'd0};
      else
         r = {4'b0000, x[3], {2'b00, x[2:1]} + 4'd6, x[0], 3'b000};
      return r;
   endfunction

   function automatic logic [12:0] cvt_e4m3(input logic [7:0] x);
      logic [12:0] r;
      if (x[6:0] == 7'h7F)
         r = {4'b0100, 9'h0FF};
      else
         r = {4'b0000, x, 1'b0};
      return r;
   endfunction

   function automatic logic [12:0] cvt_bias15(input logic s, input logic [4:0] e,
                                              input logic [9:0] m);
      logic [12:0] r;
      logic [4:0]  mant_r;
      logic [5:0]  exp_r;
      logic        up;
      r      = '0;
      up     = m[5] & ((m[4:0] != 5'd0) | m[6]);
      mant_r = {1'b0, m[9:6]} + {4'b0000, up};
      exp_r  = {1'b0, e} - 6'd8 + {5'b00000, mant_r[4]};
      if (e == 5'd31)
         r = (m != 10'd0) ? {4'b0100, 9'h0FF} : {4'b0001, s, 8'hFE};
      else if (e == 5'd0 && m == 10'd0)
         r = {4'b0000, s, 8'h00};
      else if (e < 5'd9)
         r = {4'b0010, s, 8'h00};
      // exp 15 with mant 1111 would alias the NaN code, so it saturates too
      else if (exp_r > 6'd15 || (exp_r == 6'd15 && mant_r[3:0] == 4'hF))
         r = {4'b0001, s, 8'hFE};
      else
         r = {4'b0000, s, exp_r[3:0], mant_r[3:0]};
      return r;
   endfunction

   always_comb begin
      fmt_in = F_BAD;
      if (type_ab == FP4_CODE)
         fmt_in = F_FP4;
      else if (type_ab == FP16_CODE)
         fmt_in = F_FP16;
      else if (type_ab == FP8_CODE) begin
         if (type_ab_sub == E4M3_CODE)
            fmt_in = F_E4M3;
         else if (type_ab_sub == E5M2_CODE)
            fmt_in = F_E5M2;
      end
   end

   always_comb begin
      case (fmt_q)
         F_FP4:           last_idx = IDX_W'(LAST4);
         F_E4M3, F_E5M2:  last_idx = IDX_W'(LAST8);
         F_FP16:          last_idx = IDX_W'(LAST16);
         default:         last_idx = '0;
      endcase
   end

   assign out_valid_o = (state == BUSY);
   assign last_beat   = (beat_idx == last_idx);
   assign in_ready_o  = (state == IDLE) | (out_ready_i & last_beat);
   assign accept      = in_valid_i & in_ready_o;
   assign beat_hs     = out_valid_o & out_ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fmt_q    <= F_BAD;
         a_q      <= '0;
         b_q      <= '0;
         beat_idx <= '0;
      end else if (accept) begin
         state    <= BUSY;
         fmt_q    <= fmt_in;
         a_q      <= a_i;
         b_q      <= b_i;
         beat_idx <= '0;
      end else if (beat_hs) begin
         if (last_beat) begin
            state    <= IDLE;
            beat_idx <= '0;
         end else begin
            beat_idx <= beat_idx + IDX_W'(1);
         end
      end
   end

   int unsigned idx;
   int unsigned w;
   int unsigned n;
   logic [15:0] ra;
   logic [15:0] rb;
   logic [12:0] ca;
   logic [12:0] cb;

   always_comb begin
      a_o         = '0;
      b_o         = '0;
      lane_mask_o = '0;
      flags_o     = '0;
      idx         = 0;
      ra          = '0;
      rb          = '0;
      ca          = '0;
      cb          = '0;
      case (fmt_q)
         F_FP4:           begin w = 4;  n = N4;  end
         F_E4M3, F_E5M2:  begin w = 8;  n = N8;  end
         F_FP16:          begin w = 16; n = N16; end
         default:         begin w = 0;  n = 0;   end
      endcase
      if (state == BUSY) begin
         if (fmt_q == F_BAD)
            flags_o = 4'b1000;
         for (int unsigned j = 0; j < LANES; j++) begin
            idx = 32'(beat_idx) * LANES + j;
            if (idx < n) begin
               ra = 16'(a_q >> (w * idx));
               rb = 16'(b_q >> (w * idx));
               case (fmt_q)
                  F_FP4:   begin ca = cvt_fp4(ra[3:0]);  cb = cvt_fp4(rb[3:0]);  end
                  F_E4M3:  begin ca = cvt_e4m3(ra[7:0]); cb = cvt_e4m3(rb[7:0]); end
                  F_E5M2:  begin
                     ca = cvt_bias15(ra[7], ra[6:2], {ra[1:0], 8'h00});
                     cb = cvt_bias15(rb[7], rb[6:2], {rb[1:0], 8'h00});
                  end
                  F_FP16:  begin
                     ca = cvt_bias15(ra[15], ra[14:10], ra[9:0]);
                     cb = cvt_bias15(rb[15], rb[14:10], rb[9:0]);
                  end
                  default: begin ca = '0; cb = '0; end
               endcase
               a_o[9*j +: 9]  = ca[8:0];
               b_o[9*j +: 9]  = cb[8:0];
               lane_mask_o[j] = 1'b1;
               flags_o        = flags_o | ca[12:9] | cb[12:9];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         status_o <= '0;
      else if (clr_status_i)
         status_o <= beat_hs ? flags_o : '0;
      else if (beat_hs)
         status_o <= status_o | flags_o;
   end

endmodule

// File: tb/tb_to_fp9_lanes.sv
// Scoreboard bench for to_fp9_lanes: expected beats queued at accept, checked on handshake.
module tb_to_fp9_lanes;

   localparam int unsigned BUS_W = 32;
   localparam int unsigned LANES = 4;
   localparam logic [4:0] FP4  = 5'd1;
   localparam logic [4:0] FP8  = 5'd2;
   localparam logic [4:0] FP16 = 5'd3;
   localparam logic [4:0] BADT = 5'd0;
   localparam logic [2:0] E4M3 = 3'd0;
   localparam logic [2:0] E5M2 = 3'd1;

   logic               clk = 1'b0;
   logic               rst;
   logic [4:0]         type_ab;
   logic [2:0]         type_ab_sub;
   logic [BUS_W-1:0]   a_i;
   logic [BUS_W-1:0]   b_i;
   logic               in_valid_i;
   logic               in_ready_o;
   logic [9*LANES-1:0] a_o;
   logic [9*LANES-1:0] b_o;
   logic [LANES-1:0]   lane_mask_o;
   logic               out_valid_o;
   logic               out_ready_i;
   logic [3:0]         flags_o;
   logic               clr_status_i;
   logic [3:0]         status_o;

   typedef struct {
      logic [35:0] a;
      logic [35:0] b;
      logic [3:0]  mask;
      logic [3:0]  flags;
   } beat_t;

   beat_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   to_fp9_lanes #(
      .BUS_W(BUS_W), .LANES(LANES),
      .FP4_CODE(FP4), .FP8_CODE(FP8), .FP16_CODE(FP16),
      .E4M3_CODE(E4M3), .E5M2_CODE(E5M2)
   ) dut (
      .clk(clk), .rst(rst), .type_ab(type_ab), .type_ab_sub(type_ab_sub),
      .a_i(a_i), .b_i(b_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .a_o(a_o), .b_o(b_o), .lane_mask_o(lane_mask_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .flags_o(flags_o), .clr_status_i(clr_status_i),
      .status_o(status_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && out_valid_o && out_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got a=%h b=%h mask=%b flags=%b, none expected",
                     a_o, b_o, lane_mask_o, flags_o);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            if ({a_o, b_o, lane_mask_o, flags_o} !== {e.a, e.b, e.mask, e.flags}) begin
               errors++;
               $display("FAIL beat got a=%h b=%h mask=%b flags=%b, expected a=%h b=%h mask=%b flags=%b",
                        a_o, b_o, lane_mask_o, flags_o, e.a, e.b, e.mask, e.flags);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [35:0] a, input logic [35:0] b,
                       input logic [3:0] mask, input logic [3:0] flags);
      beat_t e;
      e.a = a; e.b = b; e.mask = mask; e.flags = flags;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [4:0] t, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] b);
      logic rdy;
      rdy = 1'b0;
      type_ab = t; type_ab_sub = s; a_i = a; b_i = b; in_valid_i = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         rdy = in_ready_o;
         step();
         if (rdy) break;
      end
      // format and data lines are scrambled after accept; the block must ignore them
      in_valid_i = 1'b0; type_ab = 5'h1F; type_ab_sub = 3'h7; a_i = '1; b_i = '1;
      if (!rdy) begin
         checks++; errors++;
         $display("FAIL accept_timeout in_ready_o=%b, required 1 within 40 cycles", rdy);
      end
   endtask

   task automatic wait_drain;
      for (int n = 0; n < 40; n++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d, required 0", exp_q.size());
      end
   endtask

   function automatic logic [8:0] model16(input logic [15:0] x, output logic [3:0] fl);
      int e, q, r, ex;
      logic s;
      s  = x[15];
      e  = int'(x[14:10]);
      fl = 4'b0000;
      if (e == 31) begin
         if (x[9:0] != 10'd0) begin fl = 4'b0100; return 9'h0FF; end
         fl = 4'b0001;
         return {s, 8'hFE};
      end
      if (x[14:0] == 15'd0) return {s, 8'h00};
      if (e < 9) begin fl = 4'b0010; return {s, 8'h00}; end
      q = (1024 + int'(x[9:0])) >> 6;
      r = int'(x[9:0]) & 63;
      if (r > 32 || (r == 32 && (q % 2) == 1)) q++;
      ex = e - 8;
      if (q == 32) begin q = 16; ex++; end
      if (ex > 15 || (ex == 15 && q == 31)) begin fl = 4'b0001; return {s, 8'hFE}; end
      return {s, 4'(ex), 4'(q)};
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      step(); step();
      checks++;
      if ({out_valid_o, in_ready_o} !== 2'b01) begin
         errors++;
         $display("FAIL reset_handshake valid/ready=%b, required 01", {out_valid_o, in_ready_o});
      end
      checks++;
      if ({a_o, b_o} !== 72'h0) begin
         errors++;
         $display("FAIL reset_data a=%h b=%h, required 0", a_o, b_o);
      end
      checks++;
      if ({lane_mask_o, flags_o, status_o} !== 12'h000) begin
         errors++;
         $display("FAIL reset_status mask=%b flags=%b status=%b, required 0",
                  lane_mask_o, flags_o, status_o);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_e4m3;
      push({27'h0, 9'h07A}, {27'h0, 9'h184}, 4'hF, 4'h0);
      send(FP8, E4M3, 32'h0000_003D, 32'h0000_00C2);
      checks++;
      if (out_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL e4m3_latency out_valid_o=%b, required 1", out_valid_o);
      end
      step();
      checks++;
      if (out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL e4m3_single_beat out_valid_o=%b, required 0", out_valid_o);
      end
   endtask

   task automatic test_fp4_two_beats;
      push({9'h060, 9'h080, 9'h078, 9'h000}, 36'h0, 4'hF, 4'h0);
      push({9'h160, 9'h070, 9'h100, 9'h198}, 36'h0, 4'hF, 4'h0);
      send(FP4, 3'd0, 32'h928F_1430, 32'h0000_0000);
      checks++;
      if (in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL fp4_ready_beat0 in_ready_o=%b, required 0", in_ready_o);
      end
      wait_drain();
   endtask

   task automatic test_fp16;
      logic [15:0] a0, a1, b0, b1;
      logic [3:0]  f0, f1, f2, f3;
      logic [8:0]  ea0, ea1, eb0, eb1;
      push({9'h0, 9'h0, 9'h08B, 9'h070}, {9'h0, 9'h0, 9'h000, 9'h190}, 4'b0011, 4'h0);
      send(FP16, 3'd0, 32'h42AA_3C00, 32'h0000_C3FF);
      for (int i = 0; i < 8; i++) begin
         a0 = 16'($urandom); a1 = 16'($urandom);
         b0 = 16'($urandom); b1 = 16'($urandom);
         ea0 = model16(a0, f0); ea1 = model16(a1, f1);
         eb0 = model16(b0, f2); eb1 = model16(b1, f3);
         push({18'h0, ea1, ea0}, {18'h0, eb1, eb0}, 4'b0011, f0 | f1 | f2 | f3);
         send(FP16, 3'd0, {a1, a0}, {b1, b0});
      end
      wait_drain();
   endtask

   task automatic test_e5m2_status;
      clr_status_i = 1'b1;
      step();
      clr_status_i = 1'b0;
      push({9'h000, 9'h0FF, 9'h000, 9'h0FE}, 36'h0, 4'hF, 4'b0111);
      send(FP8, E5M2, 32'h007D_047B, 32'h0000_0000);
      step();
      checks++;
      if (status_o !== 4'b0111) begin
         errors++;
         $display("FAIL e5m2_status status_o=%b, required 0111", status_o);
      end
      clr_status_i = 1'b1;
      step();
      clr_status_i = 1'b0;
      checks++;
      if (status_o !== 4'b0000) begin
         errors++;
         $display("FAIL status_clear status_o=%b, required 0000", status_o);
      end
   endtask

   task automatic test_backpressure;
      logic [35:0] ea, eb;
      ea = {9'h0FF, 9'h070, 9'h000, 9'h100};
      eb = {9'h002, 9'h004, 9'h006, 9'h008};
      out_ready_i = 1'b0;
      push(ea, eb, 4'hF, 4'b0100);
      send(FP8, E4M3, 32'h7F38_0080, 32'h0102_0304);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({out_valid_o, in_ready_o, a_o, b_o, lane_mask_o, flags_o} !==
             {1'b1, 1'b0, ea, eb, 4'hF, 4'b0100}) begin
            errors++;
            $display("FAIL backpressure_hold cycle %0d valid=%b ready=%b a=%h b=%h mask=%b flags=%b, required 1 0 %h %h 1111 0100",
                     c, out_valid_o, in_ready_o, a_o, b_o, lane_mask_o, flags_o, ea, eb);
         end
      end
      step();
      out_ready_i = 1'b1;
      push({27'h0, 9'h07A}, {27'h0, 9'h184}, 4'hF, 4'h0);
      send(FP8, E4M3, 32'h0000_003D, 32'h0000_00C2);
      checks++;
      if (out_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back out_valid_o=%b, required 1", out_valid_o);
      end
      wait_drain();
   endtask

   task automatic test_unsupported;
      push(36'h0, 36'h0, 4'h0, 4'b1000);
      send(BADT, 3'd0, 32'hFFFF_FFFF, 32'h1234_5678);
      clr_status_i = 1'b1;
      step();
      clr_status_i = 1'b0;
      checks++;
      if (status_o !== 4'b1000) begin
         errors++;
         $display("FAIL clear_and_set status_o=%b, required 1000", status_o);
      end
      push(36'h0, 36'h0, 4'h0, 4'b1000);
      send(FP8, 3'd5, 32'h3C3C_3C3C, 32'h3C3C_3C3C);
      wait_drain();
   endtask

   task automatic test_reset_mid;
      send(FP4, 3'd0, 32'h928F_1430, 32'h1111_1111);
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      checks++;
      if ({out_valid_o, in_ready_o, status_o} !== 6'b01_0000) begin
         errors++;
         $display("FAIL reset_mid valid=%b ready=%b status=%b, required 0 1 0000",
                  out_valid_o, in_ready_o, status_o);
      end
      push({27'h0, 9'h07A}, {27'h0, 9'h184}, 4'hF, 4'h0);
      send(FP8, E4M3, 32'h0000_003D, 32'h0000_00C2);
      wait_drain();
   endtask

   initial begin
      rst = 1'b1; type_ab = '0; type_ab_sub = '0; a_i = '0; b_i = '0;
      in_valid_i = 1'b0; out_ready_i = 1'b1; clr_status_i = 1'b0;
      test_reset();
      test_e4m3();
      test_fp4_two_beats();
      test_fp16();
      test_e5m2_status();
      test_backpressure();
      test_unsupported();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
